// File: rtl/uart_pkg.sv
// Shared UART definitions.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;

  // Tick indices within one oversampled bit period.
  localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } uart_rx_state_e;

  // Clocks per oversample tick, never below one.
  function automatic int unsigned baud_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned os);
    int unsigned d;
    d = clk_hz / (baud * os);
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/axi_stream_if.sv
// Minimal AXI4-Stream bundle.
interface axi_stream_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/byte_fifo.sv
// Synchronous FIFO, count-based full/empty.
module byte_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_pop;
  logic             do_push;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling and AXI4-Stream output FIFO.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx_i,
  axi_stream_if.master rx_axis,
  output logic         frame_err,
  output logic         overrun
);

  localparam int unsigned DIV = baud_div(CLK_FREQ_HZ, BAUD, OVERSAMPLE);
  localparam int unsigned DW  = $clog2(DIV + 1);

  logic [1:0]     sync;
  logic           rxs;
  logic [DW-1:0]  div_cnt;
  logic           tick;

  uart_rx_state_e state, state_nxt;
  logic [3:0]     tcnt, tcnt_nxt;
  logic [2:0]     bidx, bidx_nxt;
  logic [7:0]     shreg, shreg_nxt;
  logic           push;
  logic           ferr_nxt;

  logic [7:0]     fifo_dout;
  logic           fifo_full;
  logic           fifo_empty;
  logic           pop;

  assign rxs = sync[1];

  // Two-flop synchroniser, idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '1;
    else     sync <= {sync[0], rx_i};
  end

  assign tick = (div_cnt == DW'(DIV - 1));

  // Free-running oversample tick divider.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DW'(1);
  end

  // Receiver state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      tcnt  <= '0;
      bidx  <= '0;
      shreg <= '0;
    end else begin
      state <= state_nxt;
      tcnt  <= tcnt_nxt;
      bidx  <= bidx_nxt;
      shreg <= shreg_nxt;
    end
  end

  // Frame recovery: next state, sampling, push and error strobes.
  always_comb begin
    state_nxt = state;
    tcnt_nxt  = tcnt;
    bidx_nxt  = bidx;
    shreg_nxt = shreg;
    push      = 1'b0;
    ferr_nxt  = 1'b0;
    if (tick) begin
      case (state)
        S_IDLE: begin
          if (!rxs) begin
            tcnt_nxt  = '0;
            state_nxt = S_START;
          end
        end
        S_START: begin
          if (tcnt == MID_TICK) begin
            if (!rxs) begin
              tcnt_nxt  = '0;
              bidx_nxt  = '0;
              state_nxt = S_DATA;
            end else begin
              state_nxt = S_IDLE;
            end
          end else begin
            tcnt_nxt = tcnt + 4'd1;
          end
        end
        S_DATA: begin
          if (tcnt == LAST_TICK) begin
            shreg_nxt = {rxs, shreg[7:1]};
            tcnt_nxt  = '0;
            if (bidx == 3'd7) state_nxt = S_STOP;
            else              bidx_nxt  = bidx + 3'd1;
          end else begin
            tcnt_nxt = tcnt + 4'd1;
          end
        end
        S_STOP: begin
          if (tcnt == LAST_TICK) begin
            tcnt_nxt = '0;
            if (rxs) begin
              push      = 1'b1;
              state_nxt = S_IDLE;
            end else begin
              ferr_nxt  = 1'b1;
              state_nxt = S_BREAK;
            end
          end else begin
            tcnt_nxt = tcnt + 4'd1;
          end
        end
        S_BREAK: begin
          if (rxs) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign pop = !fifo_empty && rx_axis.tready;

  // Registered single-cycle status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_nxt;
      overrun   <= push && fifo_full && !pop;
    end
  end

  byte_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (shreg),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rx_axis.tvalid = !fifo_empty;
  assign rx_axis.tdata  = fifo_dout;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

  logic clk = 1'b0;
  logic rst;
  logic rx_i;
  logic frame_err;
  logic overrun;

  axi_stream_if #(.DATA_W(8)) axis ();

  uart_rx #(
    .CLK_FREQ_HZ (1_843_200),
    .BAUD        (115200),
    .OVERSAMPLE  (16),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_i      (rx_i),
    .rx_axis   (axis),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int beats = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  logic [7:0] exp_q[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard and pulse counters, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (frame_err) ferr_cnt++;
      if (overrun)   ovr_cnt++;
      if (prev_stall) begin
        checks++;
        if (!axis.tvalid || axis.tdata !== prev_data) begin
          errors++;
          $display("FAIL stall_hold: tvalid=%0b tdata=%02h expected tvalid=1 tdata=%02h",
                   axis.tvalid, axis.tdata, prev_data);
        end
      end
      if (axis.tvalid && axis.tready) begin
        beats++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got %02h expected no beat", axis.tdata);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (axis.tdata !== e) begin
            errors++;
            $display("FAIL beat_data: got %02h expected %02h", axis.tdata, e);
          end
        end
      end
      prev_stall = axis.tvalid && !axis.tready;
      prev_data  = axis.tdata;
    end
  end

  // Drives start, 8 data bits LSB-first and stop; line is left at the stop level.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    @(posedge clk); #2;
    rx_i = 1'b0;
    repeat (16) @(posedge clk);
    #2;
    for (int i = 0; i < 8; i++) begin
      rx_i = d[i];
      repeat (16) @(posedge clk);
      #2;
    end
    rx_i = stop;
    repeat (16) @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input string name, input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) @(posedge clk);
    check(name, exp_q.size(), 0);
    repeat (4) @(posedge clk);
    #2;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_beat;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int b0, f0, o0;

    vecs[0] = '{8'hA5, 1'b1, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 1, 0};
    vecs[3] = '{8'h3C, 1'b0, 0, 1};
    vecs[4] = '{8'h5A, 1'b1, 1, 0};
    vecs[5] = '{8'h81, 1'b0, 0, 1};
    vecs[6] = '{8'h12, 1'b1, 1, 0};

    rst = 1'b1;
    rx_i = 1'b1;
    axis.tready = 1'b0;
    #1;
    check("reset tvalid", int'(axis.tvalid), 0);
    check("reset frame_err", int'(frame_err), 0);
    check("reset overrun", int'(overrun), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #2;

    // Table-driven single frames with tready held high.
    axis.tready = 1'b1;
    for (int v = 0; v < 7; v++) begin
      b0 = beats; f0 = ferr_cnt; o0 = ovr_cnt;
      if (vecs[v].exp_beat != 0) exp_q.push_back(vecs[v].data);
      send_frame(vecs[v].data, vecs[v].stop);
      rx_i = 1'b1;
      repeat (24) @(posedge clk);
      #2;
      check($sformatf("vec%0d beats", v), beats - b0, vecs[v].exp_beat);
      check($sformatf("vec%0d frame_err", v), ferr_cnt - f0, vecs[v].exp_ferr);
      check($sformatf("vec%0d overrun", v), ovr_cnt - o0, 0);
    end

    // Short low glitch must not produce a byte or an error.
    b0 = beats; f0 = ferr_cnt;
    rx_i = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rx_i = 1'b1;
    repeat (48) @(posedge clk);
    #2;
    check("glitch beats", beats - b0, 0);
    check("glitch frame_err", ferr_cnt - f0, 0);

    // Bad stop followed by a long break, then a normal byte.
    b0 = beats; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (40 * 16) @(posedge clk);
    #2;
    rx_i = 1'b1;
    repeat (32) @(posedge clk);
    #2;
    check("break frame_err", ferr_cnt - f0, 1);
    check("break beats", beats - b0, 0);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    wait_drain("break drain", 200);
    check("break after beats", beats - b0, 1);
    check("break after frame_err", ferr_cnt - f0, 1);

    // Overrun with the consumer stalled.
    axis.tready = 1'b0;
    o0 = ovr_cnt; b0 = beats;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1);
    end
    repeat (8) @(posedge clk);
    #2;
    check("ovr pulse", ovr_cnt - o0, 1);
    check("ovr tvalid", int'(axis.tvalid), 1);
    check("ovr head", int'(axis.tdata), 8'h01);
    axis.tready = 1'b1;
    wait_drain("ovr drain", 50);
    check("ovr beats", beats - b0, 4);
    check("ovr tvalid after", int'(axis.tvalid), 0);

    // Full FIFO, pop coincides with the stop-bit push.
    axis.tready = 1'b0;
    o0 = ovr_cnt; b0 = beats;
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(8'hB0 + 8'(i));
      send_frame(8'hB0 + 8'(i), 1'b1);
    end
    exp_q.push_back(8'hB5);
    fork
      send_frame(8'hB5, 1'b1);
      begin
        @(posedge clk);
        repeat (154) @(posedge clk);
        #3;
        axis.tready = 1'b1;
      end
    join
    wait_drain("simul drain", 50);
    check("simul overrun", ovr_cnt - o0, 0);
    check("simul beats", beats - b0, 5);

    // Reset mid-frame flushes the FIFO and the partial frame.
    axis.tready = 1'b0;
    send_frame(8'h5A, 1'b1);
    repeat (4) @(posedge clk);
    #2;
    check("rst pre tvalid", int'(axis.tvalid), 1);
    fork
      send_frame(8'h77, 1'b1);
      begin
        @(posedge clk);
        repeat (84) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst tvalid during", int'(axis.tvalid), 0);
        repeat (80) @(posedge clk);
        #3;
        rst = 1'b0;
      end
    join
    repeat (4) @(posedge clk);
    #2;
    check("rst tvalid after", int'(axis.tvalid), 0);
    b0 = beats;
    axis.tready = 1'b1;
    exp_q.push_back(8'h88);
    send_frame(8'h88, 1'b1);
    wait_drain("rst drain", 200);
    check("rst beats", beats - b0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not complete, expected finish before 2ms");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-AXI4-Stream UART receiver that feeds the UART/TCP mux's `uart_in` slave port. It synchronises the asynchronous RX pin, recovers 8N1 frames using 16x oversampling, and rejects start-bit glitches. Received bytes are buffered in a small FIFO and presented as an 8-bit AXI4-Stream. Framing errors and overruns are reported as single-cycle pulses.

## Interface
Parameters:
- `CLK_FREQ_HZ`, 50_000_000, system clock frequency.
- `BAUD`, 115200, line rate.
- `OVERSAMPLE`, 16, ticks per bit; fixed at 16.
- `FIFO_DEPTH`, 4, output buffer entries; must be a power of two, ≥2.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `rx_i`  in  1  serial line; asynchronous; idle high.
- `rx_axis`  axi_stream_if.master  8  received bytes (`tdata`, `tvalid`, `tready`).
- `frame_err`  out  1  one-cycle pulse when a stop bit samples low.
- `overrun`  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full.

## Operation
- **Synchroniser:** 2-flop synchroniser on `rx_i`, reset to 1. All logic uses the synchronised `rxs`.
- **Tick generator:**
  - `DIV = CLK_FREQ_HZ / (BAUD*16)`, integer division, clamped to ≥1.
  - Free-running counter produces a one-cycle `tick` every `DIV` clocks.
  - Counter width is `$clog2(DIV+1)`.
- **State machine:** `S_IDLE`, `S_START`, `S_DATA`, `S_STOP`, `S_BREAK`. A 4-bit tick counter `tcnt` and a 3-bit bit index `bidx` drive it.
  - **S_IDLE:** on `rxs==0` (sampled on a tick), clear `tcnt` → `S_START`.
  - **S_START:** count ticks; at `tcnt==7` (mid-bit):
    - if `rxs==0`, clear `tcnt` and `bidx` → `S_DATA`;
    - else (glitch) → `S_IDLE`.
  - **S_DATA:** at every `tcnt==15`, shift `rxs` into the shift register LSB-first. After `bidx==7` → `S_STOP`.
  - **S_STOP:** at `tcnt==15`:
    - if `rxs==1`, push the shift register into the FIFO → `S_IDLE`;
    - else pulse `frame_err`, discard the byte → `S_BREAK`.
  - **S_BREAK:** wait for `rxs==1` on a tick → `S_IDLE`. Handles a line held low (break) without emitting 0x00 bytes.
- **FIFO:**
  - `tvalid = !empty`; `tdata` = head entry.
  - Pop on `tvalid && tready`.
  - A push is accepted if `!full`, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped, `overrun` pulses, and the FIFO contents are unchanged.
- **Simultaneous push and pop when empty:** the pushed byte becomes head next cycle; there is no bypass.

## Timing
- Reset values:
  - `rx_axis.tvalid=0`, `frame_err=0`, `overrun=0`;
  - state `S_IDLE`, FIFO empty;
  - synchroniser flops and shift register to 1 / 0x00 respectively.
- Input latency: 2 clocks (synchroniser) plus ≤1 tick of start-detect jitter.
- Output latency: `tvalid` rises 1 clock after the stop-bit sample tick.
- `tdata` is stable while `tvalid && !tready` (AXI rule). `tvalid` never drops without a handshake.
- `frame_err` and `overrun` are asserted for exactly one `clk` cycle, registered.
- Reset mid-frame: the frame is lost, the FIFO is emptied, and the next start bit is received normally.
- Throughput: sustains back-to-back frames at `BAUD` with `tready` held high.

## Structure
- Shared package `uart_pkg`:
  - `uart_rx_state_e` enum;
  - `OVERSAMPLE` localparam;
  - the `uart_tx` states when that block is added.
- Sub-module `byte_fifo`: synchronous FIFO with parameters `WIDTH`, `DEPTH`.
  - Ports `push`, `din`, `pop`, `dout`, `full`, `empty`.
  - Asynchronous active-high reset.
  - Count-based full/empty with pointer wrap at `DEPTH`.
- `uart_rx` contains the synchroniser, tick generator and FSM, and instantiates one `byte_fifo`.

## Test plan
All scenarios use `CLK_FREQ_HZ=1_843_200`, `BAUD=115200` (DIV=1, 16 clocks per bit), `FIFO_DEPTH=4`.
1. Drive frame 0xA5 with `tready=1` → one `tvalid` beat with `tdata=0xA5`; `frame_err=0`, `overrun=0`.
2. Low glitch of 5 clocks on idle line → no state leaves `S_IDLE` past `S_START`; no beat and no `frame_err`.
3. Frame 0x3C with stop bit low, then line held low for 40 bit times, then released and 0x12 sent → exactly one `frame_err` pulse, no 0x00 beats; one beat 0x12.
4. `tready=0`, send 0x01..0x05 → FIFO holds 0x01..0x04 and `overrun` pulses once at byte 0x05. Raise `tready` → beats 0x01,0x02,0x03,0x04 in order, then `tvalid=0`.
5. FIFO full with `tready` asserted in the same cycle as the stop-bit push → push accepted and no `overrun`; output order is preserved.
6. Assert `rst` at bit 4 of frame 0x77, release, send 0x88 → `tvalid=0` during reset; only 0x88 is delivered.
